// File: rtl/dispatch_scheduler.sv
// In-order dispatch controller: classifies the queue head, checks station and ROB
// credits, then pops and records the dispatch or blocks the whole queue.
module dispatch_scheduler #(
    parameter int INT_DEPTH  = 4,
    parameter int FADD_DEPTH = 3,
    parameter int FMUL_DEPTH = 2,
    parameter int LSB_DEPTH  = 4,
    parameter int ROB_DEPTH  = 16,
    parameter int ROB_TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 head_valid,
    input  logic [3:0]           head_major,
    input  logic                 stall_in,
    input  logic                 rs_free_int,
    input  logic                 rs_free_fadd,
    input  logic                 rs_free_fmul,
    input  logic                 rs_free_lsb,
    input  logic                 rob_retire,
    output logic                 head_pop,
    output logic                 disp_valid,
    output logic [1:0]           disp_rs,
    output logic [ROB_TAG_W-1:0] disp_rob_tag,
    output logic                 stall_out,
    output logic                 credit_err
);

    localparam int MAX_D01 = (INT_DEPTH > FADD_DEPTH) ? INT_DEPTH : FADD_DEPTH;
    localparam int MAX_D23 = (FMUL_DEPTH > LSB_DEPTH) ? FMUL_DEPTH : LSB_DEPTH;
    localparam int MAX_D   = (MAX_D01 > MAX_D23) ? MAX_D01 : MAX_D23;
    localparam int CW      = $clog2(MAX_D + 1);
    localparam int RCW     = ROB_TAG_W + 1;

    // Station index order matches the disp_rs encoding: INT, FADD, FMUL, LSB.
    function automatic logic [CW-1:0] depth_of(input int s);
        case (s)
            0:       depth_of = CW'(INT_DEPTH);
            1:       depth_of = CW'(FADD_DEPTH);
            2:       depth_of = CW'(FMUL_DEPTH);
            default: depth_of = CW'(LSB_DEPTH);
        endcase
    endfunction

    logic [CW-1:0]        credit_q [4];
    logic [CW-1:0]        credit_d [4];
    logic [RCW-1:0]       rob_count_q;
    logic [RCW-1:0]       rob_count_d;
    logic [ROB_TAG_W-1:0] alloc_ptr_q;
    logic                 vld_p1;
    logic [1:0]           rs_p1;
    logic [ROB_TAG_W-1:0] tag_p1;
    logic                 err_q;
    logic                 err_set;

    logic       is_nop;
    logic [1:0] cls;
    logic       ready;
    logic       fire;
    logic       alloc;
    logic [3:0] free_vec;

    assign free_vec = {rs_free_lsb, rs_free_fmul, rs_free_fadd, rs_free_int};

    always_comb begin
        is_nop = 1'b0;
        cls    = 2'b00;
        case (head_major)
            4'h4:       cls    = 2'b01;
            4'h5:       cls    = 2'b10;
            4'h6, 4'h7: cls    = 2'b11;
            4'hF:       is_nop = 1'b1;
            default:    cls    = 2'b00;
        endcase
    end

    // Readiness uses only registered counts, so same-cycle frees cannot bypass.
    assign ready = is_nop | ((credit_q[cls] != '0) & (rob_count_q < RCW'(ROB_DEPTH)));
    assign fire  = head_valid & ~stall_in & ~reset & ready;
    assign alloc = fire & ~is_nop;

    assign head_pop  = fire;
    assign stall_out = head_valid & ~stall_in & ~reset & ~ready;

    always_comb begin
        err_set = 1'b0;
        for (int s = 0; s < 4; s++) begin
            credit_d[s] = credit_q[s];
            if (free_vec[s] && (credit_q[s] == depth_of(s))) begin
                err_set = 1'b1;
            end else if (free_vec[s] && !(alloc && (cls == 2'(s)))) begin
                credit_d[s] = credit_q[s] + CW'(1);
            end else if (!free_vec[s] && alloc && (cls == 2'(s))) begin
                credit_d[s] = credit_q[s] - CW'(1);
            end
        end

        rob_count_d = rob_count_q;
        case ({alloc, rob_retire})
            2'b10: rob_count_d = rob_count_q + RCW'(1);
            2'b01: begin
                if (rob_count_q == '0) err_set = 1'b1;
                else                   rob_count_d = rob_count_q - RCW'(1);
            end
            default: rob_count_d = rob_count_q;
        endcase
    end

    // Stage p1: dispatch record, one cycle after the pop decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 4; s++) credit_q[s] <= depth_of(s);
            rob_count_q <= '0;
            alloc_ptr_q <= '0;
            vld_p1      <= 1'b0;
            rs_p1       <= 2'b00;
            tag_p1      <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) credit_q[s] <= credit_d[s];
            rob_count_q <= rob_count_d;
            vld_p1      <= alloc;
            err_q       <= err_q | err_set;
            if (alloc) begin
                rs_p1       <= cls;
                tag_p1      <= alloc_ptr_q;
                alloc_ptr_q <= alloc_ptr_q + ROB_TAG_W'(1);
            end
        end
    end

    assign disp_valid   = vld_p1;
    assign disp_rs      = rs_p1;
    assign disp_rob_tag = tag_p1;
    assign credit_err   = err_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Bench for dispatch_scheduler: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of credits and ROB tags.
module tb_dispatch_scheduler;

    localparam int ROBD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       head_valid;
    logic [3:0] head_major;
    logic       stall_in;
    logic       rs_free_int, rs_free_fadd, rs_free_fmul, rs_free_lsb;
    logic       rob_retire;
    logic       head_pop;
    logic       disp_valid;
    logic [1:0] disp_rs;
    logic [3:0] disp_rob_tag;
    logic       stall_out;
    logic       credit_err;

    dispatch_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .head_valid   (head_valid),
        .head_major   (head_major),
        .stall_in     (stall_in),
        .rs_free_int  (rs_free_int),
        .rs_free_fadd (rs_free_fadd),
        .rs_free_fmul (rs_free_fmul),
        .rs_free_lsb  (rs_free_lsb),
        .rob_retire   (rob_retire),
        .head_pop     (head_pop),
        .disp_valid   (disp_valid),
        .disp_rs      (disp_rs),
        .disp_rob_tag (disp_rob_tag),
        .stall_out    (stall_out),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: free-entry counts per station, outstanding ROB tags in age order.
    int depth [4] = '{4, 3, 2, 4};
    int cred  [4];
    int rob_q [$];
    int ptr;
    bit m_dv;
    int m_rs;
    int m_tag;
    bit m_err;

    bit obs_pop, obs_stall, obs_dv, obs_err;
    int obs_tag, obs_rs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [3:0] maj);
        if (maj == 4'hF) return -1;
        if (maj == 4'h4) return 1;
        if (maj == 4'h5) return 2;
        if (maj == 4'h6 || maj == 4'h7) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) cred[s] = depth[s];
        rob_q.delete();
        ptr   = 0;
        m_dv  = 0;
        m_rs  = 0;
        m_tag = 0;
        m_err = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the model,
    // then check registered outputs at the following negedge.
    task automatic cycle(input bit hv, input logic [3:0] maj, input bit st,
                         input logic [3:0] fr, input bit ret, input bit rs_t);
        int  c;
        bit  ready, e_pop, e_stall, alloc, dec;
        head_valid   = hv;
        head_major   = maj;
        stall_in     = st;
        rs_free_int  = fr[0];
        rs_free_fadd = fr[1];
        rs_free_fmul = fr[2];
        rs_free_lsb  = fr[3];
        rob_retire   = ret;
        reset        = rs_t;
        #1;
        c = cls_of(maj);
        e_pop = 0;
        e_stall = 0;
        if (!rs_t && hv && !st) begin
            if (c < 0) ready = 1;
            else       ready = (cred[c] > 0) && (rob_q.size() < ROBD);
            e_pop   = ready;
            e_stall = !ready;
        end
        obs_pop   = head_pop;
        obs_stall = stall_out;
        check("head_pop", 32'(head_pop), 32'(e_pop));
        check("stall_out", 32'(stall_out), 32'(e_stall));

        if (rs_t) begin
            model_reset();
        end else begin
            alloc = e_pop && (c >= 0);
            for (int s = 0; s < 4; s++) begin
                dec = alloc && (c == s);
                if (fr[s]) begin
                    if (cred[s] == depth[s]) m_err = 1;
                    else if (!dec)           cred[s]++;
                end else if (dec) begin
                    cred[s]--;
                end
            end
            m_dv = alloc;
            if (alloc) begin
                rob_q.push_back(ptr);
                m_rs  = c;
                m_tag = ptr;
                ptr   = (ptr + 1) % ROBD;
            end
            if (ret) begin
                if (rob_q.size() > 0) rob_q.delete(0);
                else                  m_err = 1;
            end
        end

        @(negedge clk);
        obs_dv  = disp_valid;
        obs_rs  = int'(disp_rs);
        obs_tag = int'(disp_rob_tag);
        obs_err = credit_err;
        check("disp_valid", 32'(disp_valid), 32'(m_dv));
        check("disp_rs", 32'(disp_rs), 32'(m_rs));
        check("disp_rob_tag", 32'(disp_rob_tag), 32'(m_tag));
        check("credit_err", 32'(credit_err), 32'(m_err));
    endtask

    initial begin
        logic [3:0] fr;
        logic [3:0] maj;
        int         prev_bit;

        reset = 1'b1; head_valid = 1'b0; head_major = 4'h0; stall_in = 1'b0;
        rs_free_int = 1'b0; rs_free_fadd = 1'b0; rs_free_fmul = 1'b0; rs_free_lsb = 1'b0;
        rob_retire = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        cycle(1, 4'h1, 0, 4'b1111, 1, 1);
        check("rst_pop", 32'(obs_pop), 32'd0);
        check("rst_stall", 32'(obs_stall), 32'd0);
        check("rst_dv", 32'(obs_dv), 32'd0);
        check("rst_err", 32'(obs_err), 32'd0);

        // INT credits exhaust after four pops; a free enables a pop one cycle later
        for (int i = 0; i < 4; i++) begin
            cycle(1, 4'h1, 0, 4'b0000, 0, 0);
            check("int_pop", 32'(obs_pop), 32'd1);
            check("int_tag", 32'(obs_tag), 32'(i));
        end
        cycle(1, 4'h1, 0, 4'b0000, 0, 0);
        check("int_block_pop", 32'(obs_pop), 32'd0);
        check("int_block_stall", 32'(obs_stall), 32'd1);
        cycle(1, 4'h1, 0, 4'b0001, 0, 0);
        check("int_nobypass_pop", 32'(obs_pop), 32'd0);
        cycle(1, 4'h1, 0, 4'b0000, 0, 0);
        check("int_resume_pop", 32'(obs_pop), 32'd1);
        check("int_resume_tag", 32'(obs_tag), 32'd4);
        check("int_resume_rs", 32'(obs_rs), 32'd0);

        // FMUL head blocks the INT instruction behind it
        cycle(0, 4'h0, 0, 4'b0000, 0, 1);
        cycle(1, 4'h5, 0, 4'b0000, 0, 0);
        cycle(1, 4'h5, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 4'h5, 0, 4'b0000, 0, 0);
            check("fmul_block_pop", 32'(obs_pop), 32'd0);
            check("fmul_block_stall", 32'(obs_stall), 32'd1);
        end
        cycle(1, 4'h5, 0, 4'b0100, 0, 0);
        check("fmul_free_pop", 32'(obs_pop), 32'd0);
        cycle(1, 4'h5, 0, 4'b0000, 0, 0);
        check("fmul_pop", 32'(obs_pop), 32'd1);
        check("fmul_rs", 32'(obs_rs), 32'd2);
        cycle(1, 4'h1, 0, 4'b0000, 0, 0);
        check("int_after_fmul_rs", 32'(obs_rs), 32'd0);

        // ROB fills at sixteen, retire unblocks, tag wraps to 0
        cycle(0, 4'h0, 0, 4'b0000, 0, 1);
        prev_bit = -1;
        for (int i = 0; i < 16; i++) begin
            maj = (i % 2 == 1) ? 4'h1 : 4'h6;
            fr  = 4'b0000;
            if (prev_bit >= 0) fr[prev_bit] = 1'b1;
            cycle(1, maj, 0, fr, 0, 0);
            check("rob_fill_pop", 32'(obs_pop), 32'd1);
            check("rob_fill_tag", 32'(obs_tag), 32'(i));
            prev_bit = (i % 2 == 1) ? 0 : 3;
        end
        cycle(1, 4'h6, 0, 4'b0001, 0, 0);
        check("rob_full_pop", 32'(obs_pop), 32'd0);
        check("rob_full_stall", 32'(obs_stall), 32'd1);
        cycle(1, 4'h6, 0, 4'b0000, 1, 0);
        check("rob_retire_nobypass", 32'(obs_pop), 32'd0);
        cycle(1, 4'h6, 0, 4'b0000, 0, 0);
        check("rob_wrap_pop", 32'(obs_pop), 32'd1);
        check("rob_wrap_tag", 32'(obs_tag), 32'd0);

        // FADD free in the same cycle as a blocked head
        cycle(0, 4'h0, 0, 4'b0000, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 4'h4, 0, 4'b0000, 0, 0);
        cycle(1, 4'h4, 0, 4'b0010, 0, 0);
        check("fadd_same_cycle_pop", 32'(obs_pop), 32'd0);
        cycle(1, 4'h4, 0, 4'b0000, 0, 0);
        check("fadd_next_pop", 32'(obs_pop), 32'd1);
        cycle(1, 4'h4, 0, 4'b0000, 0, 0);
        check("fadd_empty_stall", 32'(obs_stall), 32'd1);

        // NOP pops without consuming a tag
        cycle(0, 4'h0, 0, 4'b0000, 0, 1);
        cycle(1, 4'h1, 0, 4'b0000, 0, 0);
        cycle(1, 4'hF, 0, 4'b0000, 0, 0);
        check("nop_pop", 32'(obs_pop), 32'd1);
        check("nop_dv", 32'(obs_dv), 32'd0);
        cycle(1, 4'h2, 0, 4'b0000, 0, 0);
        check("nop_next_tag", 32'(obs_tag), 32'd1);

        // stall_in freeze, overflow and underflow errors, sticky until reset
        cycle(0, 4'h0, 0, 4'b0000, 0, 1);
        cycle(1, 4'h6, 1, 4'b0000, 0, 0);
        check("stall_in_pop", 32'(obs_pop), 32'd0);
        check("stall_in_stall", 32'(obs_stall), 32'd0);
        cycle(1, 4'h6, 1, 4'b1000, 0, 0);
        check("lsb_overflow_err", 32'(obs_err), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1, 4'h6, 0, 4'b0000, 0, 0);
        check("err_sticky", 32'(obs_err), 32'd1);
        cycle(0, 4'h0, 0, 4'b0000, 0, 1);
        check("err_cleared", 32'(obs_err), 32'd0);
        cycle(0, 4'h0, 0, 4'b0000, 1, 0);
        check("rob_underflow_err", 32'(obs_err), 32'd1);
        cycle(0, 4'h0, 0, 4'b0000, 0, 1);

        // Randomized traffic with legal frees/retires and occasional resets
        for (int i = 0; i < 600; i++) begin
            fr = 4'b0000;
            for (int s = 0; s < 4; s++)
                fr[s] = (cred[s] < depth[s]) && ($urandom_range(0, 2) == 0);
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0, fr,
                  (rob_q.size() > 0) && ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
